// File: rtl/dct.sv
`default_nettype none
// dct: 8-point 1-D forward DCT-II, signed 8-bit samples in, signed 16-bit Q3 coefficients out.
// Samples are captured on wr; the transform of the held samples is registered on every edge.
module dct (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               oe,
  input  logic signed [7:0]  x0,
  input  logic signed [7:0]  x1,
  input  logic signed [7:0]  x2,
  input  logic signed [7:0]  x3,
  input  logic signed [7:0]  x4,
  input  logic signed [7:0]  x5,
  input  logic signed [7:0]  x6,
  input  logic signed [7:0]  x7,
  output logic signed [15:0] y0,
  output logic signed [15:0] y1,
  output logic signed [15:0] y2,
  output logic signed [15:0] y3,
  output logic signed [15:0] y4,
  output logic signed [15:0] y5,
  output logic signed [15:0] y6,
  output logic signed [15:0] y7
);

  localparam int NPT   = 8;
  localparam int ACC_W = 20;
  localparam logic signed [ACC_W-1:0] RND = 20'sd16;

  // Row k holds round(128*cos((2n+1)*k*pi/16)); row 0 uses 91 (128/sqrt(2)).
  localparam logic signed [7:0] COEF [NPT][NPT] = '{
    '{ 8'sd91,   8'sd91,   8'sd91,   8'sd91,   8'sd91,   8'sd91,   8'sd91,   8'sd91  },
    '{ 8'sd126,  8'sd106,  8'sd71,   8'sd25,  -8'sd25,  -8'sd71,  -8'sd106, -8'sd126 },
    '{ 8'sd118,  8'sd49,  -8'sd49,  -8'sd118, -8'sd118, -8'sd49,   8'sd49,   8'sd118 },
    '{ 8'sd106, -8'sd25,  -8'sd126, -8'sd71,   8'sd71,   8'sd126,  8'sd25,  -8'sd106 },
    '{ 8'sd91,  -8'sd91,  -8'sd91,   8'sd91,   8'sd91,  -8'sd91,  -8'sd91,   8'sd91  },
    '{ 8'sd71,  -8'sd126,  8'sd25,   8'sd106, -8'sd106, -8'sd25,   8'sd126, -8'sd71  },
    '{ 8'sd49,  -8'sd118,  8'sd118, -8'sd49,  -8'sd49,   8'sd118, -8'sd118,  8'sd49  },
    '{ 8'sd25,  -8'sd71,   8'sd106, -8'sd126,  8'sd126, -8'sd106,  8'sd71,  -8'sd25  }
  };

  logic signed [7:0]       x_in [NPT];
  logic signed [7:0]       s_q  [NPT];
  logic signed [7:0]       s_d  [NPT];
  logic signed [ACC_W-1:0] acc  [NPT];
  logic signed [15:0]      r_q  [NPT];
  logic signed [15:0]      r_d  [NPT];

  always_comb begin
    x_in[0] = x0;
    x_in[1] = x1;
    x_in[2] = x2;
    x_in[3] = x3;
    x_in[4] = x4;
    x_in[5] = x5;
    x_in[6] = x6;
    x_in[7] = x7;
  end

  always_comb begin
    for (int n = 0; n < NPT; n++) begin
      s_d[n] = wr ? x_in[n] : s_q[n];
    end
  end

  // Rounding by +16 then an arithmetic shift floors toward -inf, giving Q3 of the orthonormal DCT.
  always_comb begin
    for (int k = 0; k < NPT; k++) begin
      acc[k] = '0;
      for (int n = 0; n < NPT; n++) begin
        acc[k] = acc[k] + ACC_W'(s_q[n]) * ACC_W'(COEF[k][n]);
      end
      r_d[k] = 16'((acc[k] + RND) >>> 5);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < NPT; n++) begin
        s_q[n] <= '0;
        r_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NPT; n++) begin
        s_q[n] <= s_d[n];
        r_q[n] <= r_d[n];
      end
    end
  end

  assign y0 = oe ? r_q[0] : '0;
  assign y1 = oe ? r_q[1] : '0;
  assign y2 = oe ? r_q[2] : '0;
  assign y3 = oe ? r_q[3] : '0;
  assign y4 = oe ? r_q[4] : '0;
  assign y5 = oe ? r_q[5] : '0;
  assign y6 = oe ? r_q[6] : '0;
  assign y7 = oe ? r_q[7] : '0;

endmodule
`default_nettype wire

// File: tb/tb_dct.sv
`default_nettype none
// tb_dct: directed-vector bench for the dct block, with a cosine-based reference for random data.
module tb_dct;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic        oe;
  logic [7:0]  x [8];
  logic [15:0] y [8];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dct u_dct (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .oe    (oe),
    .x0    (x[0]), .x1 (x[1]), .x2 (x[2]), .x3 (x[3]),
    .x4    (x[4]), .x5 (x[5]), .x6 (x[6]), .x7 (x[7]),
    .y0    (y[0]), .y1 (y[1]), .y2 (y[2]), .y3 (y[3]),
    .y4    (y[4]), .y5 (y[5]), .y6 (y[6]), .y7 (y[7])
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  // e packs the expected coefficients as {y7, ..., y0}
  task automatic check_vec(input string tag, input logic [127:0] e);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s y%0d", tag, k), y[k], e[16*k +: 16]);
    end
  endtask

  function automatic logic [15:0] model(input logic [63:0] v, input int k);
    real ang;
    real cv;
    int  ci;
    int  acc;
    acc = 0;
    for (int n = 0; n < 8; n++) begin
      if (k == 0) begin
        ci = 91;
      end else begin
        ang = real'((2 * n + 1) * k) * 3.14159265358979 / 16.0;
        cv  = 128.0 * $cos(ang);
        ci  = (cv >= 0.0) ? $rtoi(cv + 0.5) : -$rtoi(-cv + 0.5);
      end
      acc = acc + int'($signed(v[8*n +: 8])) * ci;
    end
    return 16'((acc + 16) >>> 5);
  endfunction

  task automatic check_model(input string tag, input logic [63:0] v);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s y%0d", tag, k), y[k], model(v, k));
    end
  endtask

  task automatic set_x(input logic [63:0] v);
    for (int n = 0; n < 8; n++) begin
      x[n] = v[8*n +: 8];
    end
  endtask

  // Capture v, then let the compute edge pass; returns 1 time unit after that edge.
  task automatic load(input logic [63:0] v);
    @(negedge clk);
    set_x(v);
    wr = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
    set_x('x);
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0]  V_ONES  = 64'h0101_0101_0101_0101;
  localparam logic [127:0] E_ONES  = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd23};
  localparam logic [63:0]  V_IMP   = 64'h0000_0000_0000_0001;
  localparam logic [127:0] E_IMP   = {16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd4, 16'd4, 16'd3};
  localparam logic [63:0]  V_FIVE  = 64'h0000_0000_0505_0505;
  localparam logic [127:0] E_FIVE  = {-16'sd10, 16'sd0, 16'sd12, 16'sd0, -16'sd18, 16'sd0, 16'sd51, 16'sd57};
  localparam logic [63:0]  V_NEG1  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] E_NEG1  = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFE9};

  initial begin
    logic [63:0] v;
    reset = 1'b0;
    wr    = 1'b0;
    oe    = 1'b1;
    set_x('0);

    #12;
    check_vec("in_reset", '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_vec("idle", '0);

    load(V_ONES);
    check_vec("ones", E_ONES);
    oe = 1'b0;
    #1;
    check_vec("ones_oe0", '0);
    oe = 1'b1;

    load(V_IMP);
    check_vec("impulse", E_IMP);

    load(V_FIVE);
    check_vec("five", E_FIVE);
    check_model("five_model", V_FIVE);

    load(V_NEG1);
    check_vec("neg1", E_NEG1);

    // Asynchronous clear, well clear of any clock edge
    #1;
    reset = 1'b0;
    #1;
    check_vec("async_rst", '0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_vec("after_rst", '0);

    // Back-to-back captures: A at edge N, B at edge N+1
    @(negedge clk);
    set_x(V_ONES);
    wr = 1'b1;
    @(posedge clk);
    #1;
    check_vec("b2b_prev", '0);
    set_x(V_FIVE);
    @(posedge clk);
    #1;
    wr = 1'b0;
    set_x('x);
    check_vec("b2b_a", E_ONES);
    @(posedge clk);
    #1;
    check_vec("b2b_b", E_FIVE);
    repeat (3) @(posedge clk);
    set_x(64'h7F80_1234_5678_9ABC);
    repeat (3) @(posedge clk);
    #1;
    check_vec("hold", E_FIVE);

    load({8{8'h7F}});
    check_model("max", {8{8'h7F}});
    load({8{8'h80}});
    check_model("min", {8{8'h80}});
    load({4{16'h7F80}});
    check_model("alt", {4{16'h7F80}});
    load(64'h807F_7F80_807F_7F80);
    check_model("alt2", 64'h807F_7F80_807F_7F80);
    for (int i = 0; i < 6; i++) begin
      v = {$urandom(), $urandom()};
      load(v);
      check_model($sformatf("rand%0d", i), v);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
